// File: rtl/comparator_pkg.sv
// Shared types, defaults and the golden comparison rule for the comparator sweep driver.
package comparator_pkg;

    localparam int unsigned CMP_WIDTH     = 4;
    localparam int unsigned CMP_SETTLE    = 1;
    localparam int unsigned CMP_MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CHECK = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic equal;
        logic less;
        logic higher;
    } cmp_flags_t;

    // Unsigned reference result; narrower operands are zero-extended by the caller.
    function automatic cmp_flags_t cmp_golden(input logic [CMP_MAX_WIDTH-1:0] a,
                                              input logic [CMP_MAX_WIDTH-1:0] b);
        cmp_flags_t f;
        f.equal  = (a == b);
        f.less   = (a < b);
        f.higher = (a > b);
        return f;
    endfunction

endpackage

// File: rtl/comparator_sweep_driver_if.sv
// Operand/result bus between the sweep driver and the comparator under test.
interface comparator_sweep_driver_if
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH
);
    logic [WIDTH-1:0] PORT_A;
    logic [WIDTH-1:0] PORT_B;
    logic             EQUAL;
    logic             LESS;
    logic             HIGHER;

    modport master (
        output PORT_A,
        output PORT_B,
        input  EQUAL,
        input  LESS,
        input  HIGHER
    );

    modport slave (
        input  PORT_A,
        input  PORT_B,
        output EQUAL,
        output LESS,
        output HIGHER
    );
endinterface

// File: rtl/comparator_expect.sv
// Combinational golden model: expected {EQUAL, LESS, HIGHER} for the pair being driven.
module comparator_expect
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output cmp_flags_t       exp_c
);

    assign exp_c = cmp_golden(CMP_MAX_WIDTH'(a_i), CMP_MAX_WIDTH'(b_i));

endmodule

// File: rtl/comparator_sweep_driver.sv
// Exhaustive self-checking sweep of a WIDTH-bit magnitude comparator: drives every
// (A,B) pair, holds it SETTLE+1 cycles, checks the flags and keeps error bookkeeping.
module comparator_sweep_driver
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH  = CMP_WIDTH,
    parameter int unsigned SETTLE = CMP_SETTLE
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    comparator_sweep_driver_if.master cmp,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     PASS,
    output logic [2*WIDTH:0]         ERR_COUNT,
    output logic                     ERR_VALID,
    output logic [WIDTH-1:0]         FIRST_ERR_A,
    output logic [WIDTH-1:0]         FIRST_ERR_B
);

    localparam int unsigned CNT_W      = 2 * WIDTH + 1;
    localparam int unsigned SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int unsigned SETTLE_W   = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

    cmp_state_e           state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     fa_q, fa_d;
    logic [WIDTH-1:0]     fb_q, fb_d;
    logic                 pass_q, pass_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    cmp_flags_t           exp_flags;
    cmp_flags_t           obs_flags;
    logic                 mismatch;
    logic                 last_pair;

    comparator_expect #(
        .WIDTH (WIDTH)
    ) u_expect (
        .a_i   (a_q),
        .b_i   (b_q),
        .exp_c (exp_flags)
    );

    assign obs_flags = {cmp.EQUAL, cmp.LESS, cmp.HIGHER};
    // Expected flags are always one-hot, so illegal combinations fall out as mismatches.
    assign mismatch  = (obs_flags != exp_flags);
    assign last_pair = (a_q == '1) && (b_q == '1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            fa_q     <= '0;
            fb_q     <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        pass_d   = pass_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_HOLD;
                    settle_d = '0;
                    a_d      = '0;
                    b_d      = '0;
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                    fa_d     = '0;
                    fb_d     = '0;
                    pass_d   = 1'b0;
                end
            end

            ST_HOLD: begin
                if (settle_q == SETTLE_W'(SETTLE_EFF - 1)) begin
                    state_d  = ST_CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!valid_q) begin
                        valid_d = 1'b1;
                        fa_d    = a_q;
                        fb_d    = b_q;
                    end
                end
                if (last_pair) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                end else begin
                    // B is the inner loop; A steps when B wraps.
                    state_d = ST_HOLD;
                    b_d     = b_q + WIDTH'(1);
                    if (b_q == '1) begin
                        a_d = a_q + WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign cmp.PORT_A  = a_q;
    assign cmp.PORT_B  = b_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign PASS        = pass_q;
    assign ERR_COUNT   = cnt_q;
    assign ERR_VALID   = valid_q;
    assign FIRST_ERR_A = fa_q;
    assign FIRST_ERR_B = fb_q;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// Bench for comparator_sweep_driver: a fault-injectable comparator model feeds two
// driver instances (SETTLE=1 and SETTLE=3); results are checked against a sweep-level reference.
module tb_comparator_sweep_driver;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start1, start3;

    comparator_sweep_driver_if #(.WIDTH(W)) if1 ();
    comparator_sweep_driver_if #(.WIDTH(W)) if3 ();

    logic           busy1, done1, pass1, valid1;
    logic [2*W:0]   cnt1;
    logic [W-1:0]   fa1, fb1;
    logic           busy3, done3, pass3, valid3;
    logic [2*W:0]   cnt3;
    logic [W-1:0]   fa3, fb3;

    comparator_sweep_driver #(.WIDTH(W), .SETTLE(1)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start1), .cmp(if1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_COUNT(cnt1),
        .ERR_VALID(valid1), .FIRST_ERR_A(fa1), .FIRST_ERR_B(fb1)
    );

    comparator_sweep_driver #(.WIDTH(W), .SETTLE(3)) u_dut3 (
        .CLK(clk), .RST(rst), .START(start3), .cmp(if3),
        .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_COUNT(cnt3),
        .ERR_VALID(valid3), .FIRST_ERR_A(fa3), .FIRST_ERR_B(fb3)
    );

    // Comparator model: 0 correct, 1 EQUAL stuck at 0, 2 LESS/HIGHER swapped, 3 per-pair XOR fault mask
    int         mode;
    logic [2:0] fault_mask [256];

    function automatic logic [2:0] model_flags(input int md, input logic [3:0] a,
                                               input logic [3:0] b, input logic [2:0] msk);
        logic [2:0] f;
        f = {a == b, a < b, a > b};
        case (md)
            1:       f[2] = 1'b0;
            2:       f = {a == b, a > b, a < b};
            3:       f = f ^ msk;
            default: ;
        endcase
        return f;
    endfunction

    always_comb {if1.EQUAL, if1.LESS, if1.HIGHER} =
        model_flags(mode, if1.PORT_A, if1.PORT_B, fault_mask[{if1.PORT_A, if1.PORT_B}]);
    always_comb {if3.EQUAL, if3.LESS, if3.HIGHER} =
        model_flags(mode, if3.PORT_A, if3.PORT_B, fault_mask[{if3.PORT_A, if3.PORT_B}]);

    // Selected-instance view used by the shared tasks
    int           sel;
    logic         m_busy, m_done, m_pass, m_valid;
    logic [2*W:0] m_cnt;
    logic [W-1:0] m_fa, m_fb, m_pa, m_pb;

    always_comb begin
        if (sel == 3) begin
            {m_busy, m_done, m_pass, m_valid} = {busy3, done3, pass3, valid3};
            {m_cnt, m_fa, m_fb, m_pa, m_pb}   = {cnt3, fa3, fb3, if3.PORT_A, if3.PORT_B};
        end else begin
            {m_busy, m_done, m_pass, m_valid} = {busy1, done1, pass1, valid1};
            {m_cnt, m_fa, m_fb, m_pa, m_pb}   = {cnt1, fa1, fb1, if1.PORT_A, if1.PORT_B};
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel == 3) start3 = v;
        else          start1 = v;
    endtask

    task automatic chk_results(input string tag, input int cnt, input int fa, input int fb,
                               input int valid, input int pass);
        chk({tag, ".err_count"}, int'(m_cnt), cnt);
        chk({tag, ".err_valid"}, int'(m_valid), valid);
        chk({tag, ".pass"}, int'(m_pass), pass);
        if (valid != 0) begin
            chk({tag, ".first_a"}, int'(m_fa), fa);
            chk({tag, ".first_b"}, int'(m_fb), fb);
        end
    endtask

    // Starts a sweep on the selected instance and follows it to DONE. The cycle after the
    // START-sampling edge is cycle 1; the pair shown in cycle c is index (c-1)/(SETTLE+1).
    task automatic run_sweep(input bit toggle, input bit restart, input int budget,
                             output int done_cyc);
        int cyc;
        int p;
        int busy_bad = 0;
        int port_bad = 0;
        int period   = (sel == 3) ? 4 : 2;
        done_cyc = -1;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        cyc = 1;
        while (cyc <= budget) begin
            if (m_done) begin
                done_cyc = cyc;
                if (restart) set_start(1'b1);
                break;
            end
            if (!m_busy) busy_bad++;
            p = (cyc - 1) / period;
            if (int'(m_pa) != p / 16 || int'(m_pb) != p % 16) port_bad++;
            if (toggle) set_start((cyc >= 50 && cyc < 70) ? logic'(cyc % 2) : 1'b0);
            tick();
            cyc++;
        end
        if (done_cyc < 0) $display("[TB] FAIL sweep_timeout: got no DONE expected DONE within %0d cycles", budget);
        chk("busy_during_sweep_violations", busy_bad, 0);
        chk("port_sequence_violations", port_bad, 0);
        chk("busy_at_done", int'(m_busy), 0);
    endtask

    // Sweep-level reference for the XOR-mask fault: a pair fails iff its mask is nonzero.
    task automatic ref_model(output int cnt, output int fa, output int fb);
        cnt = 0; fa = 0; fb = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (fault_mask[a * 16 + b] != 3'b000) begin
                    if (cnt == 0) begin fa = a; fb = b; end
                    cnt++;
                end
            end
        end
    endtask

    typedef struct {
        int mode;
        int sel;
        int exp_cnt;
        int exp_fa;
        int exp_fb;
        int exp_valid;
        int exp_pass;
        int exp_done;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int dc;
        int rc, rfa, rfb;
        int late_done;

        tbl[0] = '{mode: 0, sel: 1, exp_cnt: 0,   exp_fa: 0, exp_fb: 0, exp_valid: 0, exp_pass: 1, exp_done: 513};
        tbl[1] = '{mode: 1, sel: 1, exp_cnt: 16,  exp_fa: 0, exp_fb: 0, exp_valid: 1, exp_pass: 0, exp_done: 513};
        tbl[2] = '{mode: 2, sel: 1, exp_cnt: 240, exp_fa: 0, exp_fb: 1, exp_valid: 1, exp_pass: 0, exp_done: 513};
        tbl[3] = '{mode: 0, sel: 3, exp_cnt: 0,   exp_fa: 0, exp_fb: 0, exp_valid: 0, exp_pass: 1, exp_done: 1025};

        for (int i = 0; i < 256; i++) fault_mask[i] = 3'b000;
        mode   = 0;
        sel    = 1;
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        tick();
        tick();

        // Reset state of both instances
        for (int s = 1; s <= 3; s += 2) begin
            sel = s;
            #0;
            chk("reset.busy", int'(m_busy), 0);
            chk("reset.done", int'(m_done), 0);
            chk("reset.port", int'({m_pa, m_pb}), 0);
            chk_results("reset", 0, 0, 0, 0, 0);
        end
        rst = 1'b0;
        tick();

        // Table-driven sweeps
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            sel  = tbl[i].sel;
            run_sweep(1'b0, 1'b0, 2 * tbl[i].exp_done, dc);
            chk("done_cycle", dc, tbl[i].exp_done);
            chk_results("table", tbl[i].exp_cnt, tbl[i].exp_fa, tbl[i].exp_fb,
                        tbl[i].exp_valid, tbl[i].exp_pass);
            tick();
            chk("done_is_pulse", int'(m_done), 0);
            tick();
            chk("hold_port_after_done", int'({m_pa, m_pb}), 8'hFF);
            chk_results("hold", tbl[i].exp_cnt, tbl[i].exp_fa, tbl[i].exp_fb,
                        tbl[i].exp_valid, tbl[i].exp_pass);
        end

        // Reset mid-sweep at cycle 100
        sel  = 1;
        mode = 2;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int c = 1; c < 100; c++) tick();
        chk("pre_reset_has_errors", int'(m_cnt != 0), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", int'(m_busy), 0);
        chk("abort.port", int'({m_pa, m_pb}), 0);
        chk_results("abort", 0, 0, 0, 0, 0);
        late_done = 0;
        for (int c = 0; c < 700; c++) begin
            if (m_done) late_done++;
            tick();
        end
        chk("no_done_after_abort", late_done, 0);
        mode = 0;
        run_sweep(1'b0, 1'b0, 1100, dc);
        chk("post_abort_done_cycle", dc, 513);
        chk_results("post_abort", 0, 0, 0, 0, 1);
        tick();

        // START toggled while busy is ignored
        run_sweep(1'b1, 1'b0, 1100, dc);
        chk("toggle_done_cycle", dc, 513);
        tick();

        // Errored sweep, restarted in its DONE cycle
        mode = 1;
        run_sweep(1'b0, 1'b1, 1100, dc);
        chk("restart_src_done_cycle", dc, 513);
        chk_results("restart_src", 16, 0, 0, 1, 0);
        tick();
        set_start(1'b0);
        chk("restart.busy", int'(m_busy), 1);
        chk("restart.err_count_cleared", int'(m_cnt), 0);
        chk("restart.err_valid_cleared", int'(m_valid), 0);
        dc = -1;
        for (int c = 1; c <= 1100; c++) begin
            if (m_done) begin dc = c; break; end
            tick();
        end
        chk("restart_done_cycle", dc, 513);
        chk_results("restart", 16, 0, 0, 1, 0);
        tick();

        // Single fault on the very last pair
        mode = 3;
        fault_mask[255] = 3'b101;
        ref_model(rc, rfa, rfb);
        run_sweep(1'b0, 1'b0, 1100, dc);
        chk("lastpair_done_cycle", dc, 513);
        chk_results("lastpair", rc, rfa, rfb, 1, 0);
        tick();

        // Randomized fault masks, alternating between instances
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++)
                fault_mask[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            ref_model(rc, rfa, rfb);
            sel = (r % 2 == 1) ? 3 : 1;
            run_sweep(1'b0, 1'b0, 2200, dc);
            chk("random_done_cycle", dc, (sel == 3) ? 1025 : 513);
            chk_results("random", rc, rfa, rfb, int'(rc != 0), int'(rc == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comparator_sweep_driver.md
# comparator_sweep_driver

Self-checking stimulus engine for the 4-bit magnitude comparator. On START it drives every (PORT_A, PORT_B) operand pair into `comparator_4_bits` and samples the returned EQUAL/LESS/HIGHER flags. It checks them against a golden model and reports the error count, the first failing pair and a pass flag. It sits on the driving end of the comparator interface: in-system built-in self-test, and a replacement for hand-listed testbench vectors.

## Interface
- WIDTH, 4: operand width; the sweep covers 2^(2*WIDTH) pairs.
- SETTLE, 1: cycles each pair is held before sampling; minimum 1.

- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  starts a sweep; sampled only in IDLE.
- PORT_A  out  WIDTH  operand A to the comparator.
- PORT_B  out  WIDTH  operand B to the comparator.
- EQUAL  in  1  comparator result, A==B.
- LESS  in  1  comparator result, A<B.
- HIGHER  in  1  comparator result, A>B.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle pulse when the sweep completes.
- PASS  out  1  ERR_COUNT==0; valid from DONE until the next START.
- ERR_COUNT  out  2*WIDTH+1  number of mismatching pairs.
- ERR_VALID  out  1  at least one mismatch captured.
- FIRST_ERR_A  out  WIDTH  A of the first mismatch.
- FIRST_ERR_B  out  WIDTH  B of the first mismatch.

## Operation
- FSM states:
  - IDLE: BUSY=0. START=1 moves to HOLD, clears ERR_COUNT, ERR_VALID, FIRST_ERR_* and PASS, and loads PORT_A=0, PORT_B=0.
  - HOLD: a settle counter runs for SETTLE cycles, then the FSM moves to CHECK.
  - CHECK: samples the flags and compares them with the golden model. On the last pair it goes to IDLE with DONE=1; otherwise it advances the pair and returns to HOLD.
- Sweep order: B is the inner loop, A the outer. (0,0), (0,1) … (0,15), (1,0) … (15,15). When B wraps to 0, A increments. The last pair is all-ones/all-ones.
- Golden model is unsigned: expected EQUAL=(A==B), LESS=(A<B), HIGHER=(A>B).
- A pair is a mismatch if any of the three flags differs from expected; illegal combinations (zero or multiple flags high) count as mismatches. Each pair counts at most once.
- On a mismatch, ERR_COUNT increments. If ERR_VALID=0, the FSM also captures FIRST_ERR_A/B and sets ERR_VALID.
- ERR_COUNT width holds 2^(2*WIDTH); no saturation logic.
- START while BUSY=1 is ignored. START in the DONE cycle (FSM already in IDLE) starts a new sweep.
- After DONE: PORT_A/B hold all-ones, and ERR_COUNT, ERR_VALID, FIRST_ERR_* and PASS hold until the next START.

## Timing
- Reset: state IDLE. PORT_A, PORT_B, BUSY, DONE, PASS, ERR_COUNT, ERR_VALID and FIRST_ERR_* are all 0.
- RST mid-sweep aborts the sweep on the next edge: all outputs go to reset values and no DONE is produced.
- Edge at which START is sampled = cycle 0. From cycle 1, BUSY=1 and PORT=(0,0).
- Each pair is driven for SETTLE+1 cycles. The flags are sampled at the rising edge that ends the hold, and the next pair appears after that edge.
- DONE=1 and BUSY=0 in cycle 2^(2*WIDTH)*(SETTLE+1)+1. For defaults that is cycle 513. PASS is valid in the same cycle.
- The comparator is combinational. SETTLE covers any pipeline or registering added in front of it.

## Structure
- Package `comparator_pkg` holds:
  - FSM state enum (IDLE, HOLD, CHECK);
  - default WIDTH and SETTLE constants;
  - the golden-result function (A, B) -> {EQUAL, LESS, HIGHER}.
- One sub-module, `comparator_expect`: combinational golden model wrapping the package function and instantiated in the driver. The FSM, pair counter, settle counter and error bookkeeping stay in the top module.

## Test plan
- Correct `comparator_4_bits`, SETTLE=1, one START pulse:
  - BUSY high for cycles 1–512; DONE pulse at cycle 513;
  - ERR_COUNT=0, ERR_VALID=0, PASS=1.
- Comparator model with EQUAL stuck at 0:
  - ERR_COUNT=16, FIRST_ERR_A=0, FIRST_ERR_B=0, ERR_VALID=1, PASS=0.
- Comparator model with LESS and HIGHER swapped:
  - ERR_COUNT=240, FIRST_ERR_A=0, FIRST_ERR_B=1.
- RST asserted at cycle 100:
  - all outputs 0 the next cycle; no DONE.
  - A following START gives a full clean sweep with DONE 513 cycles later.
- START toggled during BUSY: ignored, DONE timing unchanged.
  - Then START asserted in the DONE cycle of an errored sweep: a new sweep starts and ERR_COUNT clears to 0 the next cycle.
- SETTLE=3: PORT_A/B change every 4 cycles; DONE at cycle 1025 and PASS=1.
